// File: rtl/codeconv_pkg.sv
// Shared types and helpers for the signed-code converter pipeline.
// Mode encoding is fixed because the APB/exe_unit decode relies on it.
package codeconv_pkg;

    typedef enum logic [1:0] {
        MODE_TC2SM = 2'b00,
        MODE_SM2TC = 2'b01,
        MODE_TC2OC = 2'b10,
        MODE_OC2TC = 2'b11
    } mode_t;

    // Bit pattern of the most negative two's complement value for a given width.
    function automatic logic [63:0] min_val(input int unsigned bits);
        return 64'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/codeconv_core.sv
// Combinational conversion between two's complement, sign-magnitude and ones' complement.
// Non-negative operands pass through unchanged in every mode.
module codeconv_core
    import codeconv_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input  mode_t            mode,
    input  logic [BITS-1:0]  data,
    output logic [BITS-1:0]  result,
    output logic             err
);

    localparam logic [BITS-1:0] MinVal = BITS'(min_val(BITS));
    localparam logic [BITS-1:0] One    = BITS'(1);

    logic            sign;
    logic [BITS-1:0] tc_neg;
    logic [BITS-1:0] sm_neg;

    assign sign   = data[BITS-1];
    assign tc_neg = -data;
    // Negative zero in SM negates to plain zero, so no special case is needed.
    assign sm_neg = -{1'b0, data[BITS-2:0]};

    always_comb begin
        result = data;
        err    = 1'b0;
        if (sign) begin
            unique case (mode)
                MODE_TC2SM: begin
                    if (data == MinVal) err = 1'b1;
                    else                result = {1'b1, tc_neg[BITS-2:0]};
                end
                MODE_SM2TC: result = sm_neg;
                MODE_TC2OC: begin
                    if (data == MinVal) err = 1'b1;
                    else                result = data - One;
                end
                // All-ones (negative zero) wraps to zero on the increment.
                MODE_OC2TC: result = data + One;
            endcase
        end
    end

endmodule

// File: rtl/codeconv_pipe.sv
// Two-stage valid/ready pipeline around codeconv_core with a saturating error counter.
// Operand accepted in cycle N is presented in cycle N+2 when the output is not stalled.
module codeconv_pipe
    import codeconv_pkg::*;
#(
    parameter int unsigned BITS  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  mode_t             i_mode,
    input  logic [BITS-1:0]   i_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [BITS-1:0]   o_data,
    output logic              o_error,
    input  logic              i_clr_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic              s1_valid_q;
    mode_t             s1_mode_q;
    logic [BITS-1:0]   s1_data_q;
    logic              s2_valid_q;
    logic [BITS-1:0]   s2_data_q;
    logic              s2_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              s1_adv;
    logic              s2_adv;
    logic              in_fire;
    logic              err_xfer;
    logic [BITS-1:0]   core_result;
    logic              core_err;

    assign s2_adv   = !s2_valid_q || i_out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_fire  = i_in_valid && s1_adv;
    assign err_xfer = s2_valid_q && i_out_ready && s2_err_q;

    codeconv_core #(
        .BITS (BITS)
    ) u_core (
        .mode   (s1_mode_q),
        .data   (s1_data_q),
        .result (core_result),
        .err    (core_err)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_TC2SM;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= i_in_valid;
            if (in_fire) begin
                s1_mode_q <= i_mode;
                s1_data_q <= i_data;
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            // Output registers only move when a real result replaces them, so a stalled
            // result stays put and an emptied stage keeps its last value.
            if (s2_adv && s1_valid_q) begin
                s2_data_q <= core_result;
                s2_err_q  <= core_err;
            end
            cnt_q <= cnt_d;
        end
    end

    // Clear wins over the old count, but an errored transfer in the same cycle still counts.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = err_xfer ? CntOne : '0;
        end else if (err_xfer && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    assign o_in_ready  = s1_adv;
    assign o_out_valid = s2_valid_q;
    assign o_data      = s2_data_q;
    assign o_error     = s2_err_q;
    assign o_err_cnt   = cnt_q;

endmodule

// File: tb/tb_codeconv_pipe.sv
// Directed bench for codeconv_pipe: modes, boundaries, backpressure, counter, reset, widths.
// Four instances share clock and reset: 8/8 main, 8/2 counter, 2-bit and 16-bit sweeps.
module tb_codeconv_pipe;
    import codeconv_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    mode_t       mode;
    logic [7:0]  data;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready, out_valid, oerror;
    logic [7:0]  odata, err_cnt;
    logic        c_in_ready, c_out_valid, c_error;
    logic [7:0]  c_data;
    logic [1:0]  c_cnt;

    logic        n_in_valid, n_in_ready, n_out_valid, n_oerr;
    mode_t       n_mode;
    logic [1:0]  n_data, n_odata;
    logic [7:0]  n_cnt;
    logic        w_in_valid, w_in_ready, w_out_valid, w_oerr;
    mode_t       w_mode;
    logic [15:0] w_data, w_odata;
    logic [7:0]  w_cnt;

    int checks = 0;
    int errors = 0;

    codeconv_pipe #(.BITS(8), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_mode(mode), .i_data(data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_data(odata), .o_error(oerror), .i_clr_cnt(clr_cnt), .o_err_cnt(err_cnt)
    );

    codeconv_pipe #(.BITS(8), .CNT_W(2)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(c_in_ready),
        .i_mode(mode), .i_data(data), .o_out_valid(c_out_valid), .i_out_ready(out_ready),
        .o_data(c_data), .o_error(c_error), .i_clr_cnt(clr_cnt), .o_err_cnt(c_cnt)
    );

    codeconv_pipe #(.BITS(2), .CNT_W(8)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(n_in_valid), .o_in_ready(n_in_ready),
        .i_mode(n_mode), .i_data(n_data), .o_out_valid(n_out_valid), .i_out_ready(1'b1),
        .o_data(n_odata), .o_error(n_oerr), .i_clr_cnt(1'b0), .o_err_cnt(n_cnt)
    );

    codeconv_pipe #(.BITS(16), .CNT_W(8)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(w_in_valid), .o_in_ready(w_in_ready),
        .i_mode(w_mode), .i_data(w_data), .o_out_valid(w_out_valid), .i_out_ready(1'b1),
        .o_data(w_odata), .o_error(w_oerr), .i_clr_cnt(1'b0), .o_err_cnt(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference by value semantics: u is the raw code, full = 2**w, half = 2**(w-1).
    function automatic void model(input int w, input mode_t m, input int unsigned u,
                                  output int unsigned r, output bit e);
        int unsigned full = 32'd1 << w;
        int unsigned half = 32'd1 << (w - 1);
        bit          neg  = (u >= half);
        r = u;
        e = 1'b0;
        if (neg) begin
            case (m)
                MODE_TC2SM: if (u == half) e = 1'b1; else r = half + (full - u);
                MODE_SM2TC: r = (u == half) ? 0 : full - (u - half);
                MODE_TC2OC: if (u == half) e = 1'b1; else r = u - 1;
                MODE_OC2TC: r = (u == full - 1) ? 0 : u + 1;
                default:    r = u;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; n_in_valid = 1'b0; w_in_valid = 1'b0;
        clr_cnt = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, odata, oerror, err_cnt, in_ready} !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset: v=%b d=%h e=%b cnt=%0d rdy=%b want v=0 d=00 e=0 cnt=0 rdy=1",
                     out_valid, odata, oerror, err_cnt, in_ready);
        end
    endtask

    task automatic test_modes();
        mode_t      vm[9] = '{MODE_TC2SM, MODE_SM2TC, MODE_TC2OC, MODE_OC2TC,
                              MODE_TC2SM, MODE_SM2TC, MODE_TC2OC, MODE_OC2TC, MODE_TC2SM};
        logic [7:0] vd[9] = '{8'hFB, 8'h85, 8'hFB, 8'hFA, 8'h25, 8'h25, 8'h25, 8'h25, 8'hFB};
        logic [7:0] ve[9] = '{8'h85, 8'hFB, 8'hFA, 8'hFB, 8'h25, 8'h25, 8'h25, 8'h25, 8'h85};
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            in_valid = (c < 9);
            if (c < 9) begin mode = vm[c]; data = vd[c]; end
            @(negedge clk);
            checks++;
            if (c >= 2 && c <= 10) begin
                if ({out_valid, odata, oerror} !== {1'b1, ve[c-2], 1'b0}) begin
                    errors++;
                    $display("FAIL modes[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=0",
                             c - 2, out_valid, odata, oerror, ve[c-2]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL modes_latency c=%0d: got v=%b want v=0", c, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_boundaries();
        mode_t      vm[8] = '{MODE_TC2SM, MODE_TC2OC, MODE_SM2TC, MODE_OC2TC,
                              MODE_TC2SM, MODE_SM2TC, MODE_TC2OC, MODE_OC2TC};
        logic [7:0] vd[8] = '{8'h80, 8'h80, 8'h80, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        logic [7:0] ve[8] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        logic       vx[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            in_valid = (c < 8);
            if (c < 8) begin mode = vm[c]; data = vd[c]; end
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if ({out_valid, odata, oerror} !== {1'b1, ve[c-2], vx[c-2]}) begin
                    errors++;
                    $display("FAIL bound[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                             c - 2, out_valid, odata, oerror, ve[c-2], vx[c-2]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bound_cnt: got %0d want 2", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        mode_t       om[10];
        logic [7:0]  od[10] = '{8'hFB, 8'h80, 8'h05, 8'hFF, 8'h85, 8'h7F, 8'h00, 8'hFA,
                                8'h81, 8'h40};
        int unsigned er[10];
        bit          ee[10];
        int          sent = 0, recv = 0, stalls = 0;
        bit          held = 1'b0;
        logic [7:0]  held_d = '0;
        logic        held_e = 1'b0;
        for (int i = 0; i < 10; i++) begin
            om[i] = mode_t'(2'(i % 4));
            model(8, om[i], 32'(od[i]), er[i], ee[i]);
        end
        do_reset();
        for (int c = 0; c < 300 && recv < 10; c++) begin
            in_valid  = (sent < 10);
            if (sent < 10) begin mode = om[sent]; data = od[sent]; end
            out_ready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (held) begin
                checks++;
                if ({out_valid, odata, oerror} !== {1'b1, held_d, held_e}) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                             out_valid, odata, oerror, held_d, held_e);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({odata, oerror} !== {er[recv][7:0], ee[recv]}) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got d=%h e=%b want d=%h e=%b",
                             recv, odata, oerror, er[recv][7:0], ee[recv]);
                end
                recv++;
            end
            held   = out_valid && !out_ready;
            stalls += held ? 1 : 0;
            held_d = odata;
            held_e = oerror;
            if (in_valid && in_ready) sent++;
            tick();
        end
        checks++;
        if (recv != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 10", recv);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra: got v=%b d=%h want v=0", out_valid, odata);
            end
            tick();
        end
        if (stalls == 0) $display("note: backpressure run saw no stalls");
    endtask

    task automatic test_counter();
        do_reset();
        mode = MODE_TC2SM;
        data = 8'h80;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            tick();
        end
        checks++;
        if ({c_cnt, err_cnt} !== {2'd3, 8'd5}) begin
            errors++;
            $display("FAIL cnt_sat: got c=%0d m=%0d want c=3 m=5", c_cnt, err_cnt);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if ({c_cnt, err_cnt} !== {2'd0, 8'd0}) begin
            errors++;
            $display("FAIL cnt_clr: got c=%0d m=%0d want 0 0", c_cnt, err_cnt);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, oerror} !== 2'b11) begin
            errors++;
            $display("FAIL cnt_pre: got v=%b e=%b want v=1 e=1", out_valid, oerror);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if ({c_cnt, err_cnt} !== {2'd1, 8'd1}) begin
            errors++;
            $display("FAIL cnt_clr_err: got c=%0d m=%0d want 1 1", c_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen = 1'b0;
        do_reset();
        mode = MODE_TC2SM;
        data = 8'h80;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_pre_cnt: got %0d want 1", err_cnt);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data      = 8'h80;
        tick();
        data = 8'h81;
        tick();
        data = 8'h82;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL rst_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        tick();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, err_cnt, in_ready} !== {1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1",
                     out_valid, err_cnt, in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen |= out_valid;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_drop: got dropped operand on output want none");
        end
    endtask

    task automatic test_sweep2();
        int unsigned er[16];
        bit          ee[16];
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            n_in_valid = (c < 16);
            if (c < 16) begin
                n_mode = mode_t'(2'(c / 4));
                n_data = 2'(c % 4);
                model(2, n_mode, 32'(n_data), er[c], ee[c]);
            end
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if ({n_out_valid, n_odata, n_oerr} !== {1'b1, er[c-2][1:0], ee[c-2]}) begin
                    errors++;
                    $display("FAIL w2[%0d]: got v=%b d=%b e=%b want v=1 d=%b e=%b",
                             c - 2, n_out_valid, n_odata, n_oerr, er[c-2][1:0], ee[c-2]);
                end
            end
            tick();
        end
        n_in_valid = 1'b0;
    endtask

    task automatic test_sweep16();
        int unsigned er[200];
        bit          ee[200];
        do_reset();
        for (int c = 0; c <= 201; c++) begin
            w_in_valid = (c < 200);
            if (c < 200) begin
                w_mode = mode_t'(2'(c % 4));
                if (c < 4)      w_data = 16'h8000;
                else if (c < 8) w_data = 16'hFFFF;
                else            w_data = 16'($urandom);
                model(16, w_mode, 32'(w_data), er[c], ee[c]);
            end
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if ({w_out_valid, w_odata, w_oerr} !== {1'b1, er[c-2][15:0], ee[c-2]}) begin
                    errors++;
                    $display("FAIL w16[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                             c - 2, w_out_valid, w_odata, w_oerr, er[c-2][15:0], ee[c-2]);
                end
            end
            tick();
        end
        w_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = MODE_TC2SM; data = '0; out_ready = 1'b1;
        clr_cnt = 1'b0; n_in_valid = 1'b0; n_mode = MODE_TC2SM; n_data = '0;
        w_in_valid = 1'b0; w_mode = MODE_TC2SM; w_data = '0;
        tick();
        test_reset();
        test_modes();
        test_boundaries();
        test_backpressure();
        test_counter();
        test_reset_midstream();
        test_sweep2();
        test_sweep16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
